decode_seq: RTL

Parametrised instruction sequencer and decoder for the SM83-style CPU core. It latches the current opcode and looks up how many M-cycles the instruction needs. It then steps an M-cycle/T-cycle counter and drives the register-file control bus (read/write enables, addresses, DBUS source select) on the correct M-cycle. It sits between fetch (opcode register) and the register file / DBUS mux, and adds HALT handling, wait states and a fetch-request strobe.

---
 rtl/decode_seq.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/decode_seq.sv
// ---------------------------------------------------------------------------
// decode_seq: instruction sequencer / decoder for an SM83-style core.
//
// Latches the opcode at instruction start and looks up its M-cycle count.
// It then steps an M-cycle / T-cycle counter and drives the register-file
// control bus on the last T-cycle of the last M-cycle. It also handles HALT
// (woken by irq_pend) and pulses fetch_req so that the next opcode is latched
// on the following edge with no bubble.
//
// Optional feature macro: DECODE_WAIT_EN (adds mem_wait stall input).
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   curr_op      opcode from fetch register (sampled only at instruction start)
//   irq_pend     interrupt pending, wakes HALT
//   mem_wait     memory wait request (DECODE_WAIT_EN only)
//   reg_rd_en    register-file read enable (single-clock strobe)
//   reg_wr_en    register-file write enable (single-clock strobe)
//   reg_rd_addr  source register  (B C D E H L (HL) A = 0..7)
//   reg_wr_addr  destination register
//   reg_src_sel  DBUS source: 00 SBUS, 01 ALU, 10 MEM, 11 DEBUG
//   m_cycle      current M-cycle index
//   t_cycle      current T-cycle index
//   fetch_req    next opcode must be valid at the next clock edge
//   halted       core is in HALT
//
// Handshake: fetch_req is a one-clock pulse; whatever is on curr_op at the
// following rising edge is taken as the next opcode. There is no back-pressure
// on the fetch side.
// ---------------------------------------------------------------------------
module decode_seq #(
   parameter int T_PER_M = 4,
   parameter int MAX_M   = 6,
   parameter int MW      = 3,
   parameter int TW      = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [7:0]    curr_op,
   input  logic          irq_pend,
`ifdef DECODE_WAIT_EN
   input  logic          mem_wait,
`endif
   output logic          reg_rd_en,
   output logic          reg_wr_en,
   output logic [2:0]    reg_rd_addr,
   output logic [2:0]    reg_wr_addr,
   output logic [1:0]    reg_src_sel,
   output logic [MW-1:0] m_cycle,
   output logic [TW-1:0] t_cycle,
   output logic          fetch_req,
   output logic          halted
);

   // START exists as a named state but is absorbed: every path that would
   // enter it latches the opcode and jumps straight to EXEC M0 T0.
   typedef enum logic [1:0] {ST_HOLD, ST_START, ST_EXEC, ST_HALT} state_e;

   localparam logic [7:0]    OP_HALT = 8'h76;
   localparam logic [TW-1:0] T_LAST  = TW'(T_PER_M - 1);
   localparam logic [2:0]    R_HL    = 3'b110;
   localparam logic [2:0]    R_A     = 3'b111;
   localparam logic [1:0]    SEL_SBUS  = 2'b00;
   localparam logic [1:0]    SEL_ALU   = 2'b01;
   localparam logic [1:0]    SEL_MEM   = 2'b10;
   localparam logic [1:0]    SEL_DEBUG = 2'b11;

   state_e        state_q, state_d;
   logic [7:0]    op_lat_q, op_lat_d;
   logic [MW-1:0] m_last_q, m_last_d;     // m_count - 1
   logic [MW-1:0] m_cycle_q, m_cycle_d;
   logic [TW-1:0] t_cycle_q, t_cycle_d;
   logic [2:0]    rd_addr_q, rd_addr_d;
   logic [2:0]    wr_addr_q, wr_addr_d;
   logic [1:0]    sel_q, sel_d;

   logic last_t, last_m, strobe, stall, start, rd_en, wr_en;

   // M-cycle count per opcode, saturated to MAX_M, returned as count-1 so
   // that MAX_M = 2^MW still fits in MW bits.
   function automatic logic [MW-1:0] m_last_of(input logic [7:0] op);
      int n;
      case (op[7:6])
         2'b00:   n = 1;
         2'b01:   n = (op == OP_HALT) ? 1 :
                      ((op[2:0] == R_HL || op[5:3] == R_HL) ? 2 : 1);
         2'b10:   n = (op[2:0] == R_HL) ? 2 : 1;
         default: n = 2;
      endcase
      if (n > MAX_M) n = MAX_M;
      return MW'(n - 1);
   endfunction

`ifdef DECODE_WAIT_EN
   assign stall = mem_wait && (state_q == ST_EXEC);
`else
   assign stall = 1'b0;
`endif

   assign last_t = (t_cycle_q == T_LAST);
   assign last_m = (m_cycle_q == m_last_q);
   assign strobe = (state_q == ST_EXEC) && last_m && last_t && !stall;

   // Sequencer next-state.
   always_comb begin
      state_d   = state_q;
      op_lat_d  = op_lat_q;
      m_last_d  = m_last_q;
      m_cycle_d = m_cycle_q;
      t_cycle_d = t_cycle_q;
      start     = 1'b0;
      case (state_q)
         ST_HOLD, ST_START: start = 1'b1;
         ST_EXEC: begin
            if (!stall) begin
               if (last_t) begin
                  t_cycle_d = '0;
                  if (last_m) begin
                     if (op_lat_q == OP_HALT) begin
                        state_d   = ST_HALT;
                        m_cycle_d = '0;
                     end else begin
                        start = 1'b1;
                     end
                  end else begin
                     m_cycle_d = m_cycle_q + 1'b1;
                  end
               end else begin
                  t_cycle_d = t_cycle_q + 1'b1;
               end
            end
         end
         ST_HALT: if (irq_pend) start = 1'b1;
         default: state_d = ST_HOLD;
      endcase
      if (start) begin
         state_d   = ST_EXEC;
         op_lat_d  = curr_op;
         m_last_d  = m_last_of(curr_op);
         m_cycle_d = '0;
         t_cycle_d = '0;
      end
   end

   // Control decode. Addresses and select are shown combinationally during
   // the strobe and then held in flops until the next strobe changes them.
   always_comb begin
      rd_en     = 1'b0;
      wr_en     = 1'b0;
      rd_addr_d = rd_addr_q;
      wr_addr_d = wr_addr_q;
      sel_d     = sel_q;
      if (strobe) begin
         case (op_lat_q[7:6])
            2'b01: begin
               if (op_lat_q != OP_HALT) begin
                  rd_en     = 1'b1;
                  rd_addr_d = op_lat_q[2:0];
                  if (op_lat_q[5:3] != R_HL) begin
                     // LD r,r' / LD r,(HL); LD (HL),r only reads.
                     wr_en     = 1'b1;
                     wr_addr_d = op_lat_q[5:3];
                     sel_d     = (op_lat_q[2:0] == R_HL) ? SEL_MEM : SEL_SBUS;
                  end
               end
            end
            2'b10: begin
               rd_en     = 1'b1;
               wr_en     = 1'b1;
               rd_addr_d = op_lat_q[2:0];
               wr_addr_d = R_A;
               sel_d     = SEL_ALU;
            end
            2'b11: begin
               wr_en     = 1'b1;
               wr_addr_d = op_lat_q[5:3];
               sel_d     = SEL_DEBUG;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_HOLD;
         op_lat_q  <= 8'h00;
         m_last_q  <= '0;
         m_cycle_q <= '0;
         t_cycle_q <= '0;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         sel_q     <= '0;
      end else begin
         state_q   <= state_d;
         op_lat_q  <= op_lat_d;
         m_last_q  <= m_last_d;
         m_cycle_q <= m_cycle_d;
         t_cycle_q <= t_cycle_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         sel_q     <= sel_d;
      end
   end

   assign reg_rd_en   = rd_en;
   assign reg_wr_en   = wr_en;
   assign reg_rd_addr = rd_addr_d;
   assign reg_wr_addr = wr_addr_d;
   assign reg_src_sel = sel_d;
   assign m_cycle     = m_cycle_q;
   assign t_cycle     = t_cycle_q;
   assign fetch_req   = strobe && (op_lat_q != OP_HALT);
   assign halted      = (state_q == ST_HALT);

endmodule
